// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative
// unsigned multiply and restoring divide, one operation in flight.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rem,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULU = 3'b110;
    localparam logic [2:0] OP_DIVU = 3'b111;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    // opa: multiplicand, or dividend shifting into quotient
    // opb: multiplier, or divisor; acc: product or partial remainder
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             q_bit;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        alu_res = '0;
        case (control)
            3'b000:  alu_res = a + b;
            3'b001:  alu_res = a - b;
            3'b010:  alu_res = a & b;
            3'b011:  alu_res = a | b;
            3'b100:  alu_res = a ^ b;
            3'b101:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    end

    assign mul_acc = opb[0] ? (acc + opa) : acc;

    // The difference is below the divisor, so WIDTH bits suffice
    assign shifted = {acc, opa[WIDTH-1]};
    assign q_bit   = (shifted >= {1'b0, opb});
    assign diff    = shifted[WIDTH-1:0] - opb;
    assign div_rem = q_bit ? diff : shifted[WIDTH-1:0];
    assign div_quo = {opa[WIDTH-2:0], q_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            out   <= '0;
            rem   <= '0;
            zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (control == OP_MULU) begin
                            opa   <= a;
                            opb   <= b;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= MUL;
                        end else if (control == OP_DIVU && b != '0) begin
                            opa   <= a;
                            opb   <= b;
                            acc   <= '0;
                            cnt   <= '0;
                            state <= DIV;
                        end else if (control == OP_DIVU) begin
                            out   <= '1;
                            rem   <= a;
                            zero  <= 1'b0;
                            state <= DONE;
                        end else begin
                            out   <= alu_res;
                            rem   <= '0;
                            zero  <= ~|alu_res;
                            state <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_acc;
                    opa <= opa << 1;
                    opb <= opb >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        out   <= mul_acc;
                        rem   <= '0;
                        zero  <= ~|mul_acc;
                        state <= DONE;
                    end
                end
                DIV: begin
                    acc <= div_rem;
                    opa <= div_quo;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        out   <= div_quo;
                        rem   <= div_rem;
                        zero  <= ~|div_quo;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed WIDTH=32 table, reset/backpressure
// sequences, and a randomized WIDTH=8 run against a reference model.
module tb_seq_alu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv32 = 1'b0;
    logic        ir32;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;
    logic [2:0]  c32 = '0;
    logic        ov32;
    logic        or32 = 1'b1;
    logic [31:0] o32;
    logic [31:0] r32;
    logic        z32;

    logic        iv8 = 1'b0;
    logic        ir8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [2:0]  c8 = '0;
    logic        ov8;
    logic        or8 = 1'b1;
    logic [7:0]  o8;
    logic [7:0]  r8;
    logic        z8;

    int checks = 0;
    int failures = 0;

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .control(c32),
        .out_valid(ov32), .out_ready(or32),
        .out(o32), .rem(r32), .zero(z32)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .control(c8),
        .out_valid(ov8), .out_ready(or8),
        .out(o8), .rem(r8), .zero(z8)
    );

    typedef struct {
        logic [2:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] o;
        logic [31:0] r;
        logic        z;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // lat counts edges after the accept edge until out_valid is seen
    task automatic run32(input logic [2:0] c,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         output logic [31:0] o,
                         output logic [31:0] r,
                         output logic z,
                         output int lat);
        c32 = c;
        a32 = x;
        b32 = y;
        iv32 = 1'b1;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        a32 = $urandom;
        b32 = $urandom;
        c32 = 3'($urandom);
        lat = 0;
        while (!ov32 && lat < 100) begin
            @(posedge clk);
            #1;
            if (lat < 4) begin
                a32 = $urandom;
                b32 = $urandom;
            end
            lat++;
        end
        o = o32;
        r = r32;
        z = z32;
        if (!ov32)
            chk("timeout32", 32'(ov32), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input logic [2:0] c,
                        input logic [7:0] x,
                        input logic [7:0] y,
                        output logic [7:0] o,
                        output logic [7:0] r,
                        output logic z,
                        output int lat);
        c8 = c;
        a8 = x;
        b8 = y;
        iv8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 100) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 3'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        o = o8;
        r = r8;
        z = z8;
        if (!ov8)
            chk("timeout8", 32'(ov8), 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic void model8(input logic [2:0] c,
                                   input logic [7:0] x,
                                   input logic [7:0] y,
                                   output logic [7:0] o,
                                   output logic [7:0] r,
                                   output int lat);
        int ix;
        int iy;
        ix = int'(x);
        iy = int'(y);
        o = '0;
        r = '0;
        lat = 0;
        case (c)
            3'd0: o = 8'((ix + iy) % 256);
            3'd1: o = 8'((ix - iy + 256) % 256);
            3'd2: o = x & y;
            3'd3: o = x | y;
            3'd4: o = x ^ y;
            3'd5: o = (ix < iy) ? 8'd1 : 8'd0;
            3'd6: begin
                o = 8'((ix * iy) % 256);
                lat = 8;
            end
            default: begin
                if (iy == 0) begin
                    o = 8'hFF;
                    r = x;
                end else begin
                    o = 8'(ix / iy);
                    r = 8'(ix % iy);
                    lat = 8;
                end
            end
        endcase
    endfunction

    logic [31:0] go;
    logic [31:0] gr;
    logic        gz;
    int          gl;
    logic [7:0]  g8o;
    logic [7:0]  g8r;
    logic        g8z;
    logic [7:0]  e8o;
    logic [7:0]  e8r;
    int          e8l;
    int          seen;

    initial begin
        tbl[0]  = '{3'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b1, 0};
        tbl[1]  = '{3'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 32'd0, 1'b0, 0};
        tbl[2]  = '{3'd4, 32'hF0F0F0F0, 32'hFFFF0000,
                    32'h0F0FF0F0, 32'd0, 1'b0, 0};
        tbl[3]  = '{3'd2, 32'hF0F0F0F0, 32'hFFFF0000,
                    32'hF0F00000, 32'd0, 1'b0, 0};
        tbl[4]  = '{3'd3, 32'hF0F0F0F0, 32'hFFFF0000,
                    32'hFFFFF0F0, 32'd0, 1'b0, 0};
        tbl[5]  = '{3'd5, 32'd3, 32'h80000000, 32'd1, 32'd0, 1'b0, 0};
        tbl[6]  = '{3'd5, 32'h80000000, 32'd3, 32'd0, 32'd0, 1'b1, 0};
        tbl[7]  = '{3'd6, 32'h00012345, 32'h00010000,
                    32'h23450000, 32'd0, 1'b0, 32};
        tbl[8]  = '{3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'd1, 32'd0, 1'b0, 32};
        tbl[9]  = '{3'd7, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32};
        tbl[10] = '{3'd7, 32'd7, 32'd100, 32'd0, 32'd7, 1'b1, 32};
        tbl[11] = '{3'd7, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b0, 0};

        #1;
        chk("rst_out", o32, 32'd0);
        chk("rst_rem", r32, 32'd0);
        chk("rst_zero", 32'(z32), 32'd0);
        chk("rst_ovalid", 32'(ov32), 32'd0);
        chk("rst_iready", 32'(ir32), 32'd1);
        chk("rst_ovalid8", 32'(ov8), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            run32(tbl[i].c, tbl[i].a, tbl[i].b, go, gr, gz, gl);
            chk($sformatf("v%0d_out", i), go, tbl[i].o);
            chk($sformatf("v%0d_rem", i), gr, tbl[i].r);
            chk($sformatf("v%0d_zero", i), 32'(gz), 32'(tbl[i].z));
            chk($sformatf("v%0d_lat", i), 32'(gl), 32'(tbl[i].lat));
        end

        or32 = 1'b0;
        c32 = 3'd7;
        a32 = 32'd100;
        b32 = 32'd7;
        iv32 = 1'b1;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        gl = 0;
        while (!ov32 && gl < 100) begin
            @(posedge clk);
            #1;
            gl++;
        end
        chk("bp_lat", 32'(gl), 32'd32);
        c32 = 3'd0;
        a32 = 32'd1;
        b32 = 32'd2;
        iv32 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_out", k), o32, 32'd14);
            chk($sformatf("bp%0d_rem", k), r32, 32'd2);
            chk($sformatf("bp%0d_zero", k), 32'(z32), 32'd0);
            chk($sformatf("bp%0d_irdy", k), 32'(ir32), 32'd0);
            chk($sformatf("bp%0d_ovld", k), 32'(ov32), 32'd1);
        end
        or32 = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drain_ovld", 32'(ov32), 32'd0);
        chk("bp_drain_irdy", 32'(ir32), 32'd1);
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        chk("bp_next_ovld", 32'(ov32), 32'd1);
        chk("bp_next_out", o32, 32'd3);
        chk("bp_next_rem", r32, 32'd0);
        @(posedge clk);
        #1;

        c32 = 3'd7;
        a32 = 32'd1000;
        b32 = 32'd3;
        iv32 = 1'b1;
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        iv32 = 1'b1;
        c32 = 3'd0;
        or32 = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_out", o32, 32'd0);
        chk("arst_rem", r32, 32'd0);
        chk("arst_zero", 32'(z32), 32'd0);
        chk("arst_ovld", 32'(ov32), 32'd0);
        chk("arst_irdy", 32'(ir32), 32'd1);
        @(posedge clk);
        @(negedge clk);
        iv32 = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ov32)
                seen++;
        end
        chk("arst_no_stale", 32'(seen), 32'd0);

        for (int n = 0; n < 2000; n++) begin
            logic [2:0] rc;
            logic [7:0] ra;
            logic [7:0] rb;
            rc = 3'($urandom);
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            model8(rc, ra, rb, e8o, e8r, e8l);
            run8(rc, ra, rb, g8o, g8r, g8z, gl);
            chk($sformatf("r%0d_op%0d_out", n, rc), 32'(g8o), 32'(e8o));
            chk($sformatf("r%0d_op%0d_rem", n, rc), 32'(g8r), 32'(e8r));
            chk($sformatf("r%0d_op%0d_zero", n, rc),
                32'(g8z), 32'(e8o == 8'd0));
            chk($sformatf("r%0d_op%0d_lat", n, rc), 32'(gl), 32'(e8l));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the datapath's combinational ALU.
- Keeps the existing 3-bit opcode set for single-cycle ops and adds XOR, unsigned multiply (low half) and unsigned divide (quotient plus remainder), each iterated over WIDTH cycles.
- Sits between the execute-stage operand muxes and the EX/MEM register.
- The pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4); iteration counter width is ceil(log2(WIDTH+1)).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and control valid
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A (dividend / multiplicand)
- b  input  WIDTH  operand B (divisor / multiplier)
- control  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (unsigned), 110 mulu, 111 divu
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer takes the result this cycle
- out  output  WIDTH  result: sum, difference, logic, slt as 0/1 zero-extended, product bits [WIDTH-1:0], or quotient
- rem  output  WIDTH  divu remainder; 0 for all other ops
- zero  output  1  ~|out, registered with out

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - out, rem, zero, out_valid all 0; in_ready 1; counter 0; internal operand and accumulator registers 0.
  - Reset asserted mid-operation discards the operation; no result is produced.
- States: IDLE, MUL, DIV, DONE.
- Handshake:
  - An operation is accepted on a rising edge with in_valid=1 and in_ready=1.
  - in_ready = 1 only in IDLE.
  - In DONE: out_valid=1. out, rem and zero are held stable until an edge with out_ready=1, which moves the block to IDLE with out_valid=0.
  - No back-to-back accept in DONE: one op in flight maximum.
- Single-cycle ops (000-101):
  - On accept, the result is computed combinationally and registered.
  - State goes to DONE; out_valid is high in the cycle after accept (latency 1).
  - Add and sub wrap modulo 2^WIDTH; carry/borrow is discarded.
- mulu:
  - On accept, latch a (multiplicand), b (multiplier), clear accumulator, counter=0, state MUL.
  - Each MUL edge: if the multiplier LSB is 1, add the shifted multiplicand to the accumulator. Shift the multiplicand left and the multiplier right; counter+1.
  - The edge where counter reaches WIDTH loads out = accumulator low WIDTH bits and moves to DONE.
  - out_valid rises WIDTH cycles after accept. Upper product bits are discarded.
- divu:
  - On accept with b!=0: latch dividend and divisor, clear partial remainder, state DIV.
  - Each DIV edge does one restoring step:
    - shift the partial remainder left and bring in the dividend MSB;
    - if the partial remainder >= divisor, subtract the divisor and shift in quotient bit 1, else 0;
    - counter+1.
  - After WIDTH steps: out = quotient, rem = remainder, state DONE. Latency WIDTH.
  - divu with b==0: no iteration. out = all ones, rem = a, state DONE, latency 1.
- zero is computed from the final out value in every case.
- Inputs a, b and control are ignored while not in IDLE; changing them mid-iteration has no effect.
- If out_ready is already 1 when DONE is entered, the result is consumed on the next edge (out_valid high for exactly one cycle).

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle during DIV, with in_valid, out_ready=1 → out=0, rem=0, zero=0, out_valid=0, in_ready=1 immediately. After release, no stale result appears.
- Single-cycle ops, WIDTH=32, out_ready=1:
  - add 0xFFFFFFFF+1 → out=0, zero=1, 1-cycle latency;
  - sub 5-7 → 0xFFFFFFFE;
  - xor 0xF0F0F0F0^0xFFFF0000 → 0x0F0FF0F0;
  - slt 3,0x80000000 → 1.
- mulu, WIDTH=32: 0x00012345*0x00010000 → out=0x23450000 exactly 32 cycles after accept. 0xFFFFFFFF*0xFFFFFFFF → out=1, zero=0.
- divu, WIDTH=32: 100/7 → out=14, rem=2 at 32 cycles. 7/100 → out=0, rem=7, zero=1. 9/0 → out=0xFFFFFFFF, rem=9 at 1 cycle.
- Backpressure: out_ready=0 for 5 cycles after a divu result → out, rem and zero stable, in_ready=0. A new in_valid with different operands is not accepted until out_ready=1; the following op then runs to its correct result.
- WIDTH=8 regression: random 2000 ops against a reference model (sums mod 256, products mod 256, quotient/remainder with the div-by-zero rule). Check latency is 1 or 8 cycles per opcode.
